// File: rtl/shift_seq.sv
// Iterative 16-bit rotate/shift unit: one log-shifter stage (distance 2^k) per cycle.
// Requests are accepted only in IDLE; the result is held in DONE until out_ready.
module shift_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_amt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and ready never depends on valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [15:0] res_q, res_d;
  logic [3:0]  amt_q, amt_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  stage_q, stage_d;
  logic [15:0] stage_out;

  function automatic logic [15:0] stage_fn(input logic [15:0] x, input logic [1:0] op,
                                           input logic [1:0] k, input logic en);
    logic [4:0]  s;
    logic [15:0] y;
    s = 5'd1 << k;
    case (op)
      2'b00:   y = (x << s) | (x >> (5'd16 - s));
      2'b01:   y = x << s;
      2'b10:   y = (x >> s) | (x << (5'd16 - s));
      default: y = x >> s;
    endcase
    if (!en) y = x;
    return y;
  endfunction

  assign stage_out = stage_fn(work_q, op_q, stage_q, amt_q[stage_q]);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    res_d   = res_q;
    amt_d   = amt_q;
    op_d    = op_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          amt_d   = in_amt;
          op_d    = in_op;
          stage_d = 2'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = stage_out;
        stage_d = stage_q + 2'd1;
        if (stage_q == 2'd3) begin
          // Result gets its own register so out_data keeps the previous answer
          // while the next request is being shifted.
          res_d   = stage_out;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= 16'h0000;
      res_q   <= 16'h0000;
      amt_q   <= 4'd0;
      op_q    <= 2'd0;
      stage_q <= 2'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      res_q   <= res_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      stage_q <= stage_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_data    = res_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: hand-computed results, latency, backpressure,
// reset behaviour and back-to-back issue.
module tb_shift_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  shift_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Issues one request from IDLE, scrambles the inputs during SHIFT, and checks
  // that out_valid first rises exactly four edges after acceptance.
  task automatic run_op(input logic [15:0] d, input logic [3:0] a, input logic [1:0] op,
                        input logic [15:0] exp, input string tag);
    chk1({tag, "_in_ready_before"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    in_amt   = ~a;
    in_op    = ~op;
    for (int i = 0; i < 4; i++) begin
      chk1({tag, "_busy_shift"}, busy, 1'b1);
      chk1({tag, "_no_valid_shift"}, out_valid, 1'b0);
      chk1({tag, "_no_ready_shift"}, in_ready, 1'b0);
      tick();
    end
    chk1({tag, "_out_valid"}, out_valid, 1'b1);
    chk16({tag, "_out_data"}, out_data, exp);
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1({tag, "_in_ready_after"}, in_ready, 1'b1);
    chk1({tag, "_valid_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_amt    = 4'd0;
    in_op     = 2'd0;
    out_ready = 1'b0;
    tick();
    // Request coinciding with reset must be dropped.
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk16("rst_out_data", out_data, 16'h0000);
    tick();
    chk1("rst_req_dropped", busy, 1'b0);

    // out_ready in IDLE has no effect.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1("idle_out_ready_busy", busy, 1'b0);
    chk1("idle_out_ready_valid", out_valid, 1'b0);

    run_op(16'h8001, 4'd1, 2'b00, 16'h0003, "rol1");
    take_result("rol1");
    run_op(16'h1234, 4'd8, 2'b10, 16'h3412, "ror8");
    take_result("ror8");
    chk16("idle_retains_result", out_data, 16'h3412);
    run_op(16'h8000, 4'd15, 2'b11, 16'h0001, "srl15");
    take_result("srl15");
    run_op(16'hFFFF, 4'd0, 2'b01, 16'hFFFF, "zero_amt");
    take_result("zero_amt");
    run_op(16'h00FF, 4'd4, 2'b01, 16'h0FF0, "sll4");
    take_result("sll4");
    run_op(16'h1234, 4'd4, 2'b00, 16'h2341, "rol4");
    take_result("rol4");
    run_op(16'h0001, 4'd1, 2'b10, 16'h8000, "ror1");
    take_result("ror1");
    run_op(16'hF0F0, 4'd3, 2'b11, 16'h1E1E, "srl3");
    take_result("srl3");

    // Backpressure: hold the result for 5 cycles with an ignored request pulse.
    run_op(16'h5A5A, 4'd4, 2'b00, 16'hA5A5, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_data  = 16'h0001;
      in_amt   = 4'd1;
      in_op    = 2'b01;
      tick();
      chk1("bp_valid_held", out_valid, 1'b1);
      chk16("bp_data_held", out_data, 16'hA5A5);
      chk1("bp_in_ready_low", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    take_result("bp");
    tick();
    chk1("bp_pulse_ignored", busy, 1'b0);

    // Reset during the second SHIFT cycle aborts the operation.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    in_amt   = 4'd3;
    in_op    = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    chk1("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk16("midrst_out_data", out_data, 16'h0000);
    chk1("midrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("midrst_no_result", out_valid, 1'b0);
    end
    run_op(16'h0001, 4'd4, 2'b01, 16'h0010, "post_rst");
    take_result("post_rst");

    // Back-to-back with out_ready tied high: second accept 6 edges after the first.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h0F00;
    in_amt    = 4'd8;
    in_op     = 2'b11;
    tick();
    in_data = 16'hF000;
    in_amt  = 4'd12;
    in_op   = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("b2b_a_busy", busy, 1'b1);
    end
    tick();
    chk1("b2b_a_valid", out_valid, 1'b1);
    chk16("b2b_a_data", out_data, 16'h000F);
    tick();
    chk1("b2b_no_accept_in_done", busy, 1'b0);
    chk1("b2b_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk1("b2b_b_accepted", busy, 1'b1);
    chk16("b2b_keeps_a", out_data, 16'h000F);
    for (int i = 0; i < 3; i++) tick();
    chk1("b2b_b_not_yet", out_valid, 1'b0);
    tick();
    chk1("b2b_b_valid", out_valid, 1'b1);
    chk16("b2b_b_data", out_data, 16'h0F00);
    tick();
    out_ready = 1'b0;
    chk1("b2b_end_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
